// File: rtl/foo_mc_pkg.sv
// Shared types and helpers for the multi-channel foo accumulator.
// The typedefs describe the default build; modules derive sized locals from idx_w().
package foo_mc_pkg;

    localparam int WIDTH_DEF    = 64;
    localparam int CHANNELS_DEF = 4;
    localparam int DEPTH_DEF    = 4;
    localparam int LATENCY_DEF  = 2;

    localparam int PTR_W  = $clog2(DEPTH_DEF);
    localparam int CHAN_W = $clog2(CHANNELS_DEF);

    typedef logic [CHAN_W-1:0] chan_t;

    typedef struct packed {
        logic                 valid;
        chan_t                chan;
        logic [WIDTH_DEF-1:0] a;
        logic                 clr;
    } stage_t;

    // Index width that stays legal for n == 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/foo_mc_fifo.sv
// Per-channel operand FIFO: power-of-two depth, wrapping pointers, occupancy count.
module foo_mc_fifo
    import foo_mc_pkg::*;
#(
    parameter int DW    = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = idx_w(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign push_ok = push && (cnt_q != FULL);
    assign pop_ok  = pop && (cnt_q != '0);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + PW'(1);
        if (pop_ok)  rd_d = rd_q + PW'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (PW+1)'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/foo_mc.sv
// Multi-channel accumulator: per-channel FIFOs, round-robin issue into a shared
// non-stalling pipeline, accumulator read-modify-write only at the final stage.
module foo_mc
    import foo_mc_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    input  logic [CHANNELS*WIDTH-1:0]     in_a,
    input  logic [CHANNELS-1:0]           in_clr,
    output logic                          out_valid,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    output logic [WIDTH-1:0]              out_x,
    output logic                          out_carry
);

    localparam int CW = idx_w(CHANNELS);
    localparam int PW = idx_w(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [CW-1:0]    chan;
        logic [WIDTH-1:0] a;
        logic             clr;
    } stg_t;

    logic [CHANNELS-1:0][PW:0]    cnt;
    logic [CHANNELS-1:0][WIDTH:0] rdata;
    logic [CHANNELS-1:0]          push, grant, nonempty;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Ready comes from registered occupancy only; a same-cycle pop never frees a slot.
        assign in_ready[c] = rst_n && (cnt[c] != FULL);
        assign push[c]     = in_valid[c] && in_ready[c];
        assign nonempty[c] = (cnt[c] != '0);

        foo_mc_fifo #(.DW(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[c]),
            .wdata ({in_clr[c], in_a[c*WIDTH +: WIDTH]}),
            .pop   (grant[c]),
            .rdata (rdata[c]),
            .count (cnt[c])
        );
    end

    logic [CW-1:0] last_q, last_d, gnt_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = int'(last_q) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!found && nonempty[idx[CW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[CW-1:0];
            end
        end
        if (found) grant[gnt_idx] = 1'b1;
        last_d = found ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= '0;
        else        last_q <= last_d;
    end

    stg_t issue, fin;

    always_comb begin
        issue.valid = found;
        issue.chan  = gnt_idx;
        issue.a     = rdata[gnt_idx][WIDTH-1:0];
        issue.clr   = rdata[gnt_idx][WIDTH];
    end

    // The pop edge counts as the first stage, so only LATENCY-1 registers sit in between.
    if (LATENCY == 1) begin : g_nopipe
        assign fin = issue;
    end else begin : g_pipe
        stg_t stg_q [LATENCY-1];
        stg_t stg_d [LATENCY-1];

        always_comb begin
            stg_d[0] = issue;
            for (int k = 1; k < LATENCY - 1; k++) stg_d[k] = stg_q[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LATENCY - 1; k++) stg_q[k] <= '0;
            end else begin
                for (int k = 0; k < LATENCY - 1; k++) stg_q[k] <= stg_d[k];
            end
        end

        assign fin = stg_q[LATENCY-2];
    end

    logic [CHANNELS-1:0][WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]               base;
    logic [WIDTH:0]                 sum;
    logic                           out_valid_q, out_valid_d, out_carry_q, out_carry_d;
    logic [CW-1:0]                  out_chan_q, out_chan_d;
    logic [WIDTH-1:0]               out_x_q, out_x_d;

    always_comb begin
        acc_d       = acc_q;
        base        = fin.clr ? '0 : acc_q[fin.chan];
        sum         = {1'b0, base} + {1'b0, fin.a};
        out_valid_d = fin.valid;
        out_chan_d  = out_chan_q;
        out_x_d     = out_x_q;
        out_carry_d = out_carry_q;
        if (fin.valid) begin
            acc_d[fin.chan] = sum[WIDTH-1:0];
            out_chan_d      = fin.chan;
            out_x_d         = sum[WIDTH-1:0];
            out_carry_d     = sum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_x_q     <= '0;
            out_carry_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_x_q     <= out_x_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_x     = out_x_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_foo_mc.sv
// Scoreboard bench for foo_mc: default build driven by queued directed vectors,
// plus a CHANNELS=2 / LATENCY=1 build exercised directly.
module tb_foo_mc;

    localparam int W = 64;

    typedef struct {
        logic [1:0]   chan;
        logic [W-1:0] a;
        logic         clr;
        logic [W-1:0] x;
        logic         cy;
    } item_t;

    typedef struct {
        logic [1:0] chan;
        int         cyc;
    } log_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;

    logic [3:0]     in_valid, in_ready, in_clr;
    logic [4*W-1:0] in_a;
    logic           out_valid, out_carry;
    logic [1:0]     out_chan;
    logic [W-1:0]   out_x;

    logic [1:0]     v1, r1, c1;
    logic [2*W-1:0] a1;
    logic           ov1, ocy1;
    logic [0:0]     oc1;
    logic [W-1:0]   ox1;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    item_t sendq[$];
    item_t expq[$];
    log_t  outlog[$];
    item_t cur[4];
    logic [3:0] busy  = '0;
    logic [3:0] rdy_s = '0;
    int    acc_cyc[4];
    bit    saw_full2 = 1'b0;

    foo_mc u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_clr(in_clr), .out_valid(out_valid), .out_chan(out_chan),
        .out_x(out_x), .out_carry(out_carry)
    );

    foo_mc #(.WIDTH(W), .CHANNELS(2), .DEPTH(4), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_a(a1), .in_clr(c1), .out_valid(ov1), .out_chan(oc1),
        .out_x(ox1), .out_carry(ocy1)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic send(input int ch, input logic [W-1:0] a, input logic clr,
                        input logic [W-1:0] x, input logic cy);
        item_t it;
        it.chan = ch[1:0];
        it.a    = a;
        it.clr  = clr;
        it.x    = x;
        it.cy   = cy;
        sendq.push_back(it);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sendq.size() != 0 || busy != 0 || expq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sendq.size() + expq.size() + $countones(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    // Driver: holds each channel's head item on the port until it is accepted.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy     = '0;
            rdy_s    = '0;
            in_valid = '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (busy[c] && rdy_s[c]) begin
                    expq.push_back(cur[c]);
                    acc_cyc[c] = cyc;
                    busy[c]    = 1'b0;
                end
                if (!busy[c]) begin
                    for (int i = 0; i < sendq.size(); i++) begin
                        if (sendq[i].chan == c[1:0]) begin
                            cur[c]  = sendq[i];
                            sendq.delete(i);
                            busy[c] = 1'b1;
                            break;
                        end
                    end
                end
                in_a[c*W +: W] = cur[c].a;
                in_clr[c]      = cur[c].clr;
            end
            in_valid = busy;
            rdy_s    = in_ready;
        end
    end

    // Monitor: matches each result against the oldest pending expectation of its channel.
    initial forever begin
        int k;
        @(negedge clk);
        if (rst_n && !in_ready[2]) saw_full2 = 1'b1;
        if (rst_n && out_valid) begin
            log_t l;
            l.chan = out_chan;
            l.cyc  = cyc;
            outlog.push_back(l);
            k = -1;
            for (int i = 0; i < expq.size(); i++) begin
                if (expq[i].chan == out_chan) begin
                    k = i;
                    break;
                end
            end
            if (k < 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out chan=%0d x=%0h expected=no result", out_chan, out_x);
            end else begin
                chk($sformatf("out_ch%0d", out_chan), {out_carry, out_x}, {expq[k].cy, expq[k].x});
                expq.delete(k);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        in_valid = '0; in_clr = '0; in_a = '0;
        v1 = '0; c1 = '0; a1 = '0;
        for (int c = 0; c < 4; c++) begin
            cur[c] = '{chan: 2'(c), a: '0, clr: 1'b0, x: '0, cy: 1'b0};
            acc_cyc[c] = 0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_chan_carry", {out_chan, out_carry}, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_in_ready_l1", {ov1, r1}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 4'hF);
        chk("ready_after_rst_l1", r1, 2'b11);

        // LATENCY=1 build: accept at edge E, result at E+1
        v1 = 2'b10; a1 = '0; a1[W +: W] = 64'd5; c1 = 2'b10;
        @(negedge clk);
        v1 = '0;
        chk("l1_not_yet", ov1, 0);
        @(negedge clk);
        chk("l1_first", {ov1, oc1, ocy1, ox1}, {1'b1, 1'b1, 1'b0, 64'd5});
        @(negedge clk);
        chk("l1_strobe_hold", {ov1, oc1, ox1}, {1'b0, 1'b1, 64'd5});
        v1 = 2'b10; a1[W +: W] = 64'd7; c1 = 2'b00;
        @(negedge clk);
        v1 = '0;
        @(negedge clk);
        chk("l1_second", {ov1, oc1, ocy1, ox1}, {1'b1, 1'b1, 1'b0, 64'd12});

        // Single op with latency measurement
        send(1, 64'd5, 1'b1, 64'd5, 1'b0);
        wait_idle(50);
        chk("lat_first", outlog[outlog.size()-1].cyc - acc_cyc[1], 2);
        send(1, 64'd7, 1'b0, 64'd12, 1'b0);
        wait_idle(50);
        chk("lat_second", outlog[outlog.size()-1].cyc - acc_cyc[1], 2);

        // Leave the round-robin pointer at channel 3
        send(3, 64'd0, 1'b1, 64'd0, 1'b0);
        wait_idle(50);

        // Round-robin fairness
        outlog.delete();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send(c, 64'd1, (r == 0), 64'(r + 1), 1'b0);
        wait_idle(100);
        chk("rr_count", outlog.size(), 12);
        for (int i = 0; i < 12 && i < outlog.size(); i++) begin
            chk($sformatf("rr_chan%0d", i), outlog[i].chan, i % 4);
            chk($sformatf("rr_gap%0d", i), outlog[i].cyc - outlog[0].cyc, i);
        end

        // Full FIFO on ch2 while the other channels keep the arbiter busy
        saw_full2 = 1'b0;
        outlog.delete();
        for (int c = 0; c < 4; c++) begin
            if (c != 2) begin
                send(c, 64'd0, 1'b1, 64'd0, 1'b0);
                for (int k = 1; k <= 5; k++) send(c, 64'd1, 1'b0, 64'(k), 1'b0);
            end
        end
        send(2, 64'd10, 1'b1, 64'd10, 1'b0);
        send(2, 64'd1, 1'b0, 64'd11, 1'b0);
        send(2, 64'd2, 1'b0, 64'd13, 1'b0);
        send(2, 64'd3, 1'b0, 64'd16, 1'b0);
        send(2, 64'd4, 1'b0, 64'd20, 1'b0);
        send(2, 64'd5, 1'b0, 64'd25, 1'b0);
        wait_idle(200);
        chk("ch2_saw_full", saw_full2, 1);
        begin
            int n2;
            n2 = 0;
            foreach (outlog[i]) if (outlog[i].chan == 2'd2) n2++;
            chk("ch2_result_count", n2, 6);
        end

        // Wrap and carry
        send(0, {W{1'b1}}, 1'b1, {W{1'b1}}, 1'b0);
        send(0, 64'd2, 1'b0, 64'd1, 1'b1);
        send(0, 64'd0, 1'b0, 64'd1, 1'b0);
        wait_idle(50);

        // Reset in the middle of traffic
        send(0, 64'd1, 1'b0, 64'd2, 1'b0);  send(0, 64'd1, 1'b0, 64'd3, 1'b0);
        send(1, 64'd1, 1'b0, 64'd6, 1'b0);  send(1, 64'd1, 1'b0, 64'd7, 1'b0);
        send(2, 64'd1, 1'b0, 64'd26, 1'b0); send(2, 64'd1, 1'b0, 64'd27, 1'b0);
        send(3, 64'd1, 1'b0, 64'd6, 1'b0);  send(3, 64'd1, 1'b0, 64'd7, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out", {out_valid, out_chan, out_carry, out_x}, 0);
        chk("midrst_ready", in_ready, 0);
        sendq.delete();
        expq.delete();
        outlog.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_out", outlog.size(), 0);
        for (int c = 0; c < 4; c++) send(c, 64'd0, 1'b0, 64'd0, 1'b0);
        wait_idle(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
